// File: rtl/tile_delta_encoder_pkg.sv
// Shared types and default configuration for the tile delta encoder.
package tile_delta_encoder_pkg;

  typedef enum logic [1:0] {FILL, FINAL, DRAIN} enc_state_t;

  localparam int unsigned DEF_NUM_PIX   = 32;
  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_CH_W      = 8;
  localparam int unsigned DEF_BEAT_PIX  = 8;
  localparam int unsigned DEF_RES_W_MAX = 4;
  localparam int unsigned DEF_RW_W      = $clog2(DEF_CH_W + 1);

  typedef struct packed {
    logic [DEF_NUM_CH-1:0]                skip;
    logic [DEF_NUM_CH-1:0][DEF_CH_W-1:0]  min;
    logic [DEF_NUM_CH-1:0][DEF_RW_W-1:0]  resw;
  } enc_header_t;

endpackage

// File: rtl/tile_delta_encoder_range_tracker.sv
// channel_range_tracker: running min/max of one channel across the beats of a tile.
module channel_range_tracker
  import tile_delta_encoder_pkg::*;
#(
  parameter int unsigned BEAT_PIX = DEF_BEAT_PIX,
  parameter int unsigned CH_W     = DEF_CH_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     update,
  input  logic [BEAT_PIX*CH_W-1:0] vals,
  output logic [CH_W-1:0]          min_val,
  output logic [CH_W-1:0]          max_val
);

  logic [CH_W-1:0] next_min;
  logic [CH_W-1:0] next_max;

  // Fold the whole beat into the running extremes in one combinational pass.
  always_comb begin
    next_min = min_val;
    next_max = max_val;
    for (int unsigned p = 0; p < BEAT_PIX; p++) begin
      if (vals[p*CH_W +: CH_W] < next_min) next_min = vals[p*CH_W +: CH_W];
      if (vals[p*CH_W +: CH_W] > next_max) next_max = vals[p*CH_W +: CH_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      min_val <= '1;
      max_val <= '0;
    end else if (update) begin
      min_val <= next_min;
      max_val <= next_max;
    end
  end

endmodule

// File: rtl/tile_delta_encoder.sv
// Buffers one tile, then emits header plus min-relative residuals (or raw beats).
// Optional tile statistics ports under QS_ENC_PERF_EN.
module tile_delta_encoder
  import tile_delta_encoder_pkg::*;
#(
  parameter int unsigned NUM_PIX   = DEF_NUM_PIX,
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned CH_W      = DEF_CH_W,
  parameter int unsigned BEAT_PIX  = DEF_BEAT_PIX,
  parameter int unsigned RES_W_MAX = DEF_RES_W_MAX,
  localparam int unsigned RW_W     = $clog2(CH_W + 1),
  localparam int unsigned BEAT_W   = BEAT_PIX * NUM_CH * CH_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BEAT_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BEAT_W-1:0]      out_data,
  output logic                   out_first,
  output logic                   out_last,
  output logic [NUM_CH-1:0]      out_skip,
  output logic [NUM_CH*CH_W-1:0] out_min,
  output logic [NUM_CH*RW_W-1:0] out_resw,
`ifdef QS_ENC_PERF_EN
  output logic [31:0]            tiles_comp,
  output logic [31:0]            tiles_raw,
`endif
  output logic                   out_compressable
);

  localparam int unsigned NB   = NUM_PIX / BEAT_PIX;
  localparam int unsigned BC_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(NB - 1);

  enc_state_t state, state_next;
  logic [BC_W-1:0]   beat_cnt;
  logic [BEAT_W-1:0] buf_mem [NB];

  logic in_fire, out_fire, fill_done, drain_done;

  logic [NUM_CH-1:0][BEAT_PIX*CH_W-1:0] ch_vals;
  logic [NUM_CH-1:0][CH_W-1:0]          trk_min, trk_max;

  logic [NUM_CH-1:0]           skip_q, skip_d;
  logic [NUM_CH-1:0][CH_W-1:0] min_q;
  logic [NUM_CH-1:0][RW_W-1:0] resw_q, resw_d;
  logic                        comp_q, comp_d;

  function automatic logic [RW_W-1:0] bit_len(input logic [CH_W-1:0] v);
    bit_len = '0;
    for (int unsigned i = 0; i < CH_W; i++)
      if (v[i]) bit_len = RW_W'(i + 1);
  endfunction

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign fill_done  = in_fire && (beat_cnt == LAST_BEAT);
  assign drain_done = out_fire && (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FILL:    if (fill_done)  state_next = FINAL;
      FINAL:                   state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = FILL;
      default:                 state_next = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state == FILL) && !rst;
    out_valid = (state == DRAIN);
    out_first = (state == DRAIN) && (beat_cnt == '0);
    out_last  = (state == DRAIN) && (beat_cnt == LAST_BEAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (in_fire || out_fire) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end
  end

  // Buffer contents need no reset: beat_cnt restarts at 0 and every slot is rewritten before drain.
  always_ff @(posedge clk) begin
    if (in_fire) buf_mem[beat_cnt] <= in_data;
  end

  always_comb begin
    ch_vals = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      for (int unsigned p = 0; p < BEAT_PIX; p++)
        ch_vals[c][p*CH_W +: CH_W] = in_data[(p*NUM_CH + c)*CH_W +: CH_W];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_trk
    channel_range_tracker #(
      .BEAT_PIX (BEAT_PIX),
      .CH_W     (CH_W)
    ) u_trk (
      .clk     (clk),
      .rst     (rst),
      .clear   (drain_done),
      .update  (in_fire),
      .vals    (ch_vals[c]),
      .min_val (trk_min[c]),
      .max_val (trk_max[c])
    );
  end

  always_comb begin
    skip_d = '0;
    resw_d = '0;
    comp_d = 1'b1;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      skip_d[c] = (trk_max[c] == trk_min[c]);
      resw_d[c] = bit_len(trk_max[c] - trk_min[c]);
      if (resw_d[c] > RW_W'(RES_W_MAX)) comp_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_q <= '0;
      min_q  <= '0;
      resw_q <= '0;
      comp_q <= 1'b0;
    end else if (state == FINAL) begin
      skip_q <= skip_d;
      min_q  <= trk_min;
      resw_q <= resw_d;
      comp_q <= comp_d;
    end
  end

  assign out_skip         = skip_q;
  assign out_min          = min_q;
  assign out_resw         = resw_q;
  assign out_compressable = comp_q;

  always_comb begin
    out_data = buf_mem[beat_cnt];
    if (comp_q) begin
      for (int unsigned p = 0; p < BEAT_PIX; p++)
        for (int unsigned c = 0; c < NUM_CH; c++)
          out_data[(p*NUM_CH + c)*CH_W +: CH_W] =
            buf_mem[beat_cnt][(p*NUM_CH + c)*CH_W +: CH_W] - min_q[c];
    end
  end

`ifdef QS_ENC_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tiles_comp <= '0;
      tiles_raw  <= '0;
    end else if (state == FINAL) begin
      if (comp_d) begin
        if (tiles_comp != '1) tiles_comp <= tiles_comp + 32'd1;
      end else begin
        if (tiles_raw != '1) tiles_raw <= tiles_raw + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/tile_delta_encoder.md
# tile_delta_encoder

Parametrised successor to the fixed 32-pixel RGBA header/residual stages. It accepts a tile of pixels as a stream of beats and buffers the whole tile while tracking per-channel min/max. It then emits a header containing skip flags, per-channel minima and residual bit-widths, followed by the tile as min-relative residuals, or as raw pixels when the tile is not compressable. It sits between the frame fetch and the compress/commit stage of the compression pipeline.

## Interface
- NUM_PIX, 32, pixels per tile
- NUM_CH, 4, channels per pixel
- CH_W, 8, bits per channel
- BEAT_PIX, 8, pixels per beat; NUM_PIX % BEAT_PIX == 0; NB = NUM_PIX/BEAT_PIX beats per tile
- RES_W_MAX, 4, largest residual width still counted compressable
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  high only in FILL and when rst is low
- in_data  in  BEAT_PIX*NUM_CH*CH_W  pixel p, channel c at bits [(p*NUM_CH+c)*CH_W +: CH_W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  BEAT_PIX*NUM_CH*CH_W  residual or raw beat, same packing as in_data
- out_first, out_last  out  1 each  first/last beat of tile
- out_skip  out  NUM_CH  channel c constant across tile
- out_min  out  NUM_CH*CH_W  per-channel minimum
- out_resw  out  NUM_CH*RW_W  per-channel residual width; RW_W = $clog2(CH_W+1)
- out_compressable  out  1  all out_resw <= RES_W_MAX

## Operation
- FSM states FILL, FINAL, DRAIN; reset state FILL.
- FILL: on each in_valid&&in_ready, write beat to buffer slot beat_cnt, update running min/max per channel over all BEAT_PIX pixels, beat_cnt++. When the handshake occurs at beat_cnt == NB-1, go to FINAL and clear beat_cnt.
- FINAL: exactly one cycle. Register skip[c] = (max==min). Register resw[c] = bits needed for max-min, i.e. $clog2(max-min+1), 0 when skip. Register compressable.
- DRAIN: present buffer slot beat_cnt. If compressable, each channel = pixel - min[c], zero-extended to CH_W bits (always < 2^resw). Otherwise out_data is raw. Advance on out_valid&&out_ready. After the handshake on beat NB-1, go to FILL, set min regs to all-ones, set max regs to 0, clear beat_cnt.
- Header outputs are held constant for every beat of a tile. out_first = (beat_cnt==0), out_last = (beat_cnt==NB-1), both qualified by DRAIN.
- Output is not accepted in FILL and input is not accepted in DRAIN; the block holds a single tile with no overlap.
- in_data is ignored when in_valid is low.

## Timing
- Reset values: in_ready 0 while rst is high, out_valid 0, out_first/out_last 0, header outputs 0, beat_cnt 0, min regs all-ones, max regs 0.
- in_ready is 1 in the first cycle after rst deasserts.
- Reset mid-tile, in FILL or DRAIN, discards the buffer contents. The next accepted beat is beat 0 of a fresh tile.
- If the last FILL handshake is at edge k: FINAL spans k..k+1, and out_valid is high from edge k+1.
- Once out_valid is high, out_data and the header hold stable until out_ready is sampled high; out_valid does not drop before the handshake.
- Tile occupancy: NB + 1 + NB cycles with no stalls.
- Min/max update is combinational over one beat and registered at the handshake edge; there is no extra pipeline stage.

## Configuration
- QS_ENC_PERF_EN defined: adds output ports tiles_comp and tiles_raw, 32 bits each, both reset to 0. Exactly one of them increments at the FINAL cycle, according to compressable. Both saturate at 2^32-1.
- Undefined: those ports and counters are absent; all other behaviour is identical.

## Structure
- Shared types package gains:
  - enc_state_t enum {FILL, FINAL, DRAIN}
  - localparams for the default config (32 pixels, 4 channels, 8 bits, RES_W_MAX 4)
  - a packed enc_header_t for the default config: skip[3:0], min[3:0][7:0], resw[3:0][3:0]
- Sub-module channel_range_tracker, one instance per channel. It takes BEAT_PIX values plus a clear and an update enable, and returns registered min/max.

## Test plan
- All 32 pixels (10,20,30,40) -> skip=1111, mins 10/20/30/40, resw all 0, compressable=1, 4 beats of all-zero data, first/last on beats 0/3.
- R = pixel index 0..31, G/B/A = 5 -> R resw=5, compressable=0, out_data equals input beats bit-exact.
- R = 100+(i%16), others constant -> R min 100, resw 4, compressable=1, R residual = i%16.
- Same tile with out_ready pattern 1,0,1,0,... -> data/header stable during stalls, exactly 4 handshakes, in_ready 0 throughout DRAIN.
- rst for 1 cycle after 2 input beats of ramp, then 4 constant-(7,7,7,7) beats -> skip=1111, min 7 on all channels.
- With QS_ENC_PERF_EN, run tiles 1,2,3 back-to-back -> tiles_comp=2, tiles_raw=1.
